// File: rtl/spw_ulight_chan_bridge.sv
// Host register bridge for NCH SpaceWire ulight cores: CTRL/STATUS, TX handshakes, RX FIFO and timecode.
// Optional registered irq output is built when SPW_BRIDGE_IRQ_EN is defined.

module spw_bridge_txfsm #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         ready,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         en,
    output logic         busy,
    output logic         drop
);
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_STROBE} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (load)  state_nxt = S_PEND;
            S_PEND:   if (ready) state_nxt = S_STROBE;
            S_STROBE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // strobe decoded from the state register so reset removes it at once
    always_comb begin
        en   = (state == S_STROBE);
        busy = (state != S_IDLE);
        drop = load && (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          dout <= '0;
        else if (load && state == S_IDLE) dout <= din;
    end
endmodule

module spw_bridge_chan #(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        rd,
    input  logic [2:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        link_start,
    output logic        link_disable,
    output logic        auto_start,
    output logic        send_fct_now,
    output logic [8:0]  data_tx,
    output logic        data_en,
    input  logic        data_tx_ready,
    output logic [7:0]  timec_tx,
    output logic        timec_en,
    input  logic        timec_tx_ready,
    input  logic [8:0]  data_rx,
    input  logic        data_rx_ready,
    input  logic [7:0]  timec_rx,
    input  logic        timec_rx_ready,
    input  logic [5:0]  fsm_info,
    input  logic        credit_error_rx,
    output logic        irq_cond
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RX_DEPTH);

    logic wr_ctrl, wr_stat, wr_txd, wr_txtc, rd_rxd, rd_rxtc;
    assign wr_ctrl = wr && sel == 3'd0;
    assign wr_stat = wr && sel == 3'd1;
    assign wr_txd  = wr && sel == 3'd2;
    assign wr_txtc = wr && sel == 3'd3;
    assign rd_rxd  = rd && sel == 3'd4;
    assign rd_rxtc = rd && sel == 3'd5;

    logic [2:0] ctrl;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl         <= '0;
            send_fct_now <= 1'b0;
        end else begin
            send_fct_now <= wr_ctrl && wdata[3];
            if (wr_ctrl) ctrl <= wdata[2:0];
        end
    end
    assign {auto_start, link_disable, link_start} = ctrl;

    logic tx_busy, tc_busy, txd_drop, txtc_drop;
    spw_bridge_txfsm #(.W(9)) u_txd (
        .clk(clk), .rst(rst), .load(wr_txd), .ready(data_tx_ready), .din(wdata[8:0]),
        .dout(data_tx), .en(data_en), .busy(tx_busy), .drop(txd_drop)
    );
    spw_bridge_txfsm #(.W(8)) u_txtc (
        .clk(clk), .rst(rst), .load(wr_txtc), .ready(timec_tx_ready), .din(wdata[7:0]),
        .dout(timec_tx), .en(timec_en), .busy(tc_busy), .drop(txtc_drop)
    );

    logic [8:0]    mem [RX_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic          rx_prev, push, pop, full, do_push;
    assign push    = data_rx_ready && !rx_prev;
    assign pop     = rd_rxd && cnt != '0;
    assign full    = (cnt == FULL);
    // a pop frees the slot the same cycle, so a full FIFO still accepts
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= data_rx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev <= 1'b0;
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
        end else begin
            rx_prev <= data_rx_ready;
            if (do_push) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            case ({do_push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    logic       tc_prev, tc_vld, tc_edge;
    logic [7:0] tc_data;
    assign tc_edge = timec_rx_ready && !tc_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_prev <= 1'b0;
            tc_vld  <= 1'b0;
            tc_data <= '0;
        end else begin
            tc_prev <= timec_rx_ready;
            if (tc_edge) begin
                tc_data <= timec_rx;
                tc_vld  <= 1'b1;
            end else if (rd_rxtc) begin
                tc_vld  <= 1'b0;
            end
        end
    end

    logic       credit_err, rx_ovf, tc_ovr, tx_drop;
    logic [3:0] clr;
    assign clr = wr_stat ? wdata[9:6] : 4'b0;

    // set has priority over clear; credit_err cannot clear while the input holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_err <= 1'b0;
            rx_ovf     <= 1'b0;
            tc_ovr     <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (credit_error_rx)                 credit_err <= 1'b1;
            else if (clr[0])                     credit_err <= 1'b0;
            if (push && full && !pop)            rx_ovf     <= 1'b1;
            else if (clr[1])                     rx_ovf     <= 1'b0;
            if (tc_edge && tc_vld && !rd_rxtc)   tc_ovr     <= 1'b1;
            else if (clr[2])                     tc_ovr     <= 1'b0;
            if (txd_drop || txtc_drop)           tx_drop    <= 1'b1;
            else if (clr[3])                     tx_drop    <= 1'b0;
        end
    end

    logic [2:0] ie;
`ifdef SPW_BRIDGE_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   ie <= '0;
        else if (wr && sel == 3'd6) ie <= wdata[2:0];
    end
    assign irq_cond = (ie[0] && cnt != '0) || (ie[1] && tc_vld) ||
                      (ie[2] && (credit_err || rx_ovf || tc_ovr || tx_drop));
`else
    assign ie       = 3'b0;
    assign irq_cond = 1'b0;
`endif

    logic [15:0] status;
    assign status = {4'(cnt), tc_busy, tx_busy, tx_drop, tc_ovr, rx_ovf, credit_err, fsm_info};

    always_comb begin
        rdata = '0;
        case (sel)
            3'd0:    rdata = {29'b0, ctrl};
            3'd1:    rdata = {16'b0, status};
            3'd4:    if (cnt != '0) rdata = {1'b1, 22'b0, mem[rp]};
            3'd5:    rdata = {tc_vld, 23'b0, tc_data};
            3'd6:    rdata = {29'b0, ie};
            default: rdata = '0;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:10];
endmodule

module spw_ulight_chan_bridge #(
    parameter int NCH      = 2,
    parameter int RX_DEPTH = 4,
    parameter int ADDR_W   = $clog2(NCH) + 3
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic [NCH-1:0]    link_start,
    output logic [NCH-1:0]    link_disable,
    output logic [NCH-1:0]    auto_start,
    output logic [NCH-1:0]    send_fct_now,
    output logic [9*NCH-1:0]  data_tx_to_w,
    output logic [NCH-1:0]    data_en_to_w,
    input  logic [NCH-1:0]    data_tx_ready,
    output logic [8*NCH-1:0]  timec_tx_to_w,
    output logic [NCH-1:0]    timec_en_to_tx,
    input  logic [NCH-1:0]    timec_tx_ready,
    input  logic [9*NCH-1:0]  data_rx_r,
    input  logic [NCH-1:0]    data_rx_ready,
    input  logic [8*NCH-1:0]  timec_rx_r,
    input  logic [NCH-1:0]    timec_rx_ready,
    input  logic [6*NCH-1:0]  fsm_info,
    input  logic [NCH-1:0]    credit_error_rx
`ifdef SPW_BRIDGE_IRQ_EN
    ,
    output logic              irq
`endif
);
    logic [ADDR_W-1:0]      chan;
    logic [NCH-1:0][31:0]   ch_rdata;
    logic [NCH-1:0]         irq_cond;
    logic [31:0]            rd_mux;
    assign chan = address >> 3;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic hit;
        assign hit = (chan == ADDR_W'(i));
        spw_bridge_chan #(.RX_DEPTH(RX_DEPTH)) u_chan (
            .clk(clk_clk), .rst(reset_reset), .wr(write && hit), .rd(read && hit),
            .sel(address[2:0]), .wdata(writedata), .rdata(ch_rdata[i]),
            .link_start(link_start[i]), .link_disable(link_disable[i]),
            .auto_start(auto_start[i]), .send_fct_now(send_fct_now[i]),
            .data_tx(data_tx_to_w[9*i +: 9]), .data_en(data_en_to_w[i]),
            .data_tx_ready(data_tx_ready[i]),
            .timec_tx(timec_tx_to_w[8*i +: 8]), .timec_en(timec_en_to_tx[i]),
            .timec_tx_ready(timec_tx_ready[i]),
            .data_rx(data_rx_r[9*i +: 9]), .data_rx_ready(data_rx_ready[i]),
            .timec_rx(timec_rx_r[8*i +: 8]), .timec_rx_ready(timec_rx_ready[i]),
            .fsm_info(fsm_info[6*i +: 6]), .credit_error_rx(credit_error_rx[i]),
            .irq_cond(irq_cond[i])
        );
    end

    // unpopulated channel slots fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++)
            if (chan == ADDR_W'(i)) rd_mux = ch_rdata[i];
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) readdata <= '0;
        else             readdata <= read ? rd_mux : '0;
    end

`ifdef SPW_BRIDGE_IRQ_EN
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) irq <= 1'b0;
        else             irq <= |irq_cond;
    end
`else
    logic unused_irq;
    assign unused_irq = |irq_cond;
`endif
endmodule

// File: tb/tb_spw_ulight_chan_bridge.sv
// Scoreboard bench for spw_ulight_chan_bridge (NCH=2, RX_DEPTH=4); irq checks when SPW_BRIDGE_IRQ_EN is defined.

module tb_spw_ulight_chan_bridge;
    localparam int NCH = 2, RX_DEPTH = 4, ADDR_W = 4;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [ADDR_W-1:0] address;
    logic              write, read;
    logic [31:0]       writedata, readdata;
    logic [NCH-1:0]    link_start, link_disable, auto_start, send_fct_now;
    logic [9*NCH-1:0]  data_tx_to_w, data_rx_r;
    logic [NCH-1:0]    data_en_to_w, data_tx_ready, timec_en_to_tx, timec_tx_ready;
    logic [8*NCH-1:0]  timec_tx_to_w, timec_rx_r;
    logic [NCH-1:0]    data_rx_ready, timec_rx_ready, credit_error_rx;
    logic [6*NCH-1:0]  fsm_info;
`ifdef SPW_BRIDGE_IRQ_EN
    logic              irq;
`endif

    always #5 clk_clk = ~clk_clk;

    spw_ulight_chan_bridge #(.NCH(NCH), .RX_DEPTH(RX_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .link_start(link_start), .link_disable(link_disable), .auto_start(auto_start),
        .send_fct_now(send_fct_now), .data_tx_to_w(data_tx_to_w), .data_en_to_w(data_en_to_w),
        .data_tx_ready(data_tx_ready), .timec_tx_to_w(timec_tx_to_w),
        .timec_en_to_tx(timec_en_to_tx), .timec_tx_ready(timec_tx_ready),
        .data_rx_r(data_rx_r), .data_rx_ready(data_rx_ready), .timec_rx_r(timec_rx_r),
        .timec_rx_ready(timec_rx_ready), .fsm_info(fsm_info), .credit_error_rx(credit_error_rx)
`ifdef SPW_BRIDGE_IRQ_EN
        , .irq(irq)
`endif
    );

    int          nvec = 0, nfail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [8:0]  rx_model[$];
    logic        rd_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // readdata is compared on the falling edge following the read's sampling edge
    always @(posedge clk_clk) rd_seen <= read;
    always @(negedge clk_clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else                   check(tag_q.pop_front(), readdata, exp_q.pop_front());
        end
    end

    task automatic host_wr(input int a, input logic [31:0] d);
        @(negedge clk_clk);
        address = ADDR_W'(a); writedata = d; write = 1'b1;
        @(negedge clk_clk);
        write = 1'b0;
    endtask

    task automatic host_rd(input int a, input logic [31:0] e, input string tag);
        @(negedge clk_clk);
        address = ADDR_W'(a); read = 1'b1;
        exp_q.push_back(e); tag_q.push_back(tag);
        @(negedge clk_clk);
        read = 1'b0;
    endtask

    task automatic rx_push(input logic [8:0] v);
        @(negedge clk_clk);
        data_rx_r[8:0] = v; data_rx_ready[0] = 1'b1;
        if (rx_model.size() < RX_DEPTH) rx_model.push_back(v);
        @(negedge clk_clk);
        data_rx_ready[0] = 1'b0;
    endtask

    task automatic rd_rxd(input string tag);
        logic [31:0] e;
        e = '0;
        if (rx_model.size() != 0) e = {1'b1, 22'b0, rx_model.pop_front()};
        host_rd(4, e, tag);
    endtask

    task automatic tc_push(input logic [7:0] v);
        @(negedge clk_clk);
        timec_rx_r[15:8] = v; timec_rx_ready[1] = 1'b1;
        @(negedge clk_clk);
        timec_rx_ready[1] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        data_tx_ready = '0; timec_tx_ready = '0; data_rx_r = '0; data_rx_ready = '0;
        timec_rx_r = '0; timec_rx_ready = '0; fsm_info = '0; credit_error_rx = '0;
        repeat (3) @(negedge clk_clk);
        check("rst_outs", 32'({link_start, link_disable, auto_start, send_fct_now,
                               data_en_to_w, timec_en_to_tx}), 32'd0);
        check("rst_txd", 32'(data_tx_to_w), 32'd0);
        check("rst_rdata", readdata, 32'd0);
        reset_reset = 1'b0;

        host_rd(0, 32'h0, "ctrl0_rst");
        host_rd(1, 32'h0, "stat0_rst");
        fsm_info[5:0] = 6'h05;
        host_rd(1, 32'h005, "stat0_fsm");

        // TX data handshake on ch1 with core not ready
        host_wr(10, 32'h1A5);
        check("txd_nostrobe", 32'(data_en_to_w), 32'd0);
        host_rd(9, 32'h400, "stat1_busy");
        host_wr(10, 32'h0FF);
        host_rd(9, 32'h600, "stat1_drop");
        data_tx_ready[1] = 1'b1;
        @(negedge clk_clk);
        check("txd_strobe", 32'(data_en_to_w), 32'd2);
        check("txd_data", 32'(data_tx_to_w[17:9]), 32'h1A5);
        @(negedge clk_clk);
        check("txd_strobe_1cyc", 32'(data_en_to_w), 32'd0);
        host_rd(9, 32'h200, "stat1_idle");
        host_wr(9, 32'h200);
        host_rd(9, 32'h0, "stat1_w1c");

        // minimum latency with ready already high
        host_wr(10, 32'h055);
        check("txd_lat1", 32'(data_en_to_w), 32'd0);
        @(negedge clk_clk);
        check("txd_lat2", 32'(data_en_to_w), 32'd2);
        check("txd_lat2_data", 32'(data_tx_to_w[17:9]), 32'h055);
        @(negedge clk_clk);
        check("txd_lat3", 32'(data_en_to_w), 32'd0);
        data_tx_ready = '0;

        // RX FIFO overflow and drain
        rx_push(9'h101); rx_push(9'h002); rx_push(9'h1F3); rx_push(9'h044); rx_push(9'h155);
        host_rd(1, 32'h4085, "stat0_full_ovf");
        for (int k = 0; k < 5; k++) rd_rxd("rx_drain");
        host_rd(1, 32'h0085, "stat0_empty_ovf");
        host_wr(1, 32'h080);
        host_rd(1, 32'h005, "stat0_ovf_clr");

        // full FIFO with simultaneous pop and push
        rx_push(9'h0A1); rx_push(9'h0A2); rx_push(9'h0A3); rx_push(9'h0A4);
        @(negedge clk_clk);
        address = 4'd4; read = 1'b1; data_rx_r[8:0] = 9'h0A5; data_rx_ready[0] = 1'b1;
        exp_q.push_back({1'b1, 22'b0, rx_model.pop_front()}); tag_q.push_back("rx_simul");
        rx_model.push_back(9'h0A5);
        @(negedge clk_clk);
        read = 1'b0; data_rx_ready[0] = 1'b0;
        host_rd(1, 32'h4005, "stat0_simul");
        for (int k = 0; k < 4; k++) rd_rxd("rx_simul_drain");

        // RX timecode overrun and same-cycle read
        tc_push(8'h11); tc_push(8'h22);
        host_rd(13, 32'h80000022, "rxtc_ovr");
        host_rd(9, 32'h100, "stat1_tcovr");
        host_wr(9, 32'h100);
        host_rd(9, 32'h0, "stat1_tcovr_clr");
        tc_push(8'h33);
        @(negedge clk_clk);
        address = 4'd13; read = 1'b1; timec_rx_r[15:8] = 8'h44; timec_rx_ready[1] = 1'b1;
        exp_q.push_back(32'h80000033); tag_q.push_back("rxtc_simul_old");
        @(negedge clk_clk);
        read = 1'b0; timec_rx_ready[1] = 1'b0;
        host_rd(13, 32'h80000044, "rxtc_simul_new");

        // CTRL and FCT pulse
        host_wr(0, 32'hD);
        check("fct_pulse", 32'(send_fct_now), 32'd1);
        check("ctrl_outs", 32'({auto_start[0], link_disable[0], link_start[0]}), 32'd5);
        @(negedge clk_clk);
        check("fct_1cyc", 32'(send_fct_now), 32'd0);
        host_rd(0, 32'h5, "ctrl0_rb");

        // credit error sticky held by input
        credit_error_rx[0] = 1'b1;
        @(negedge clk_clk);
        host_rd(1, 32'h045, "stat0_credit");
        host_wr(1, 32'h040);
        host_rd(1, 32'h045, "stat0_credit_held");
        credit_error_rx[0] = 1'b0;
        host_wr(1, 32'h040);
        host_rd(1, 32'h005, "stat0_credit_clr");

        // TX timecode handshake on ch0
        host_wr(3, 32'h3C);
        host_rd(1, 32'h805, "stat0_tcbusy");
        host_wr(3, 32'h5A);
        host_rd(1, 32'hA05, "stat0_tcdrop");
        timec_tx_ready[0] = 1'b1;
        @(negedge clk_clk);
        check("txtc_strobe", 32'(timec_en_to_tx), 32'd1);
        check("txtc_data", 32'(timec_tx_to_w[7:0]), 32'h3C);
        @(negedge clk_clk);
        check("txtc_strobe_1cyc", 32'(timec_en_to_tx), 32'd0);
        host_wr(1, 32'h200);
        host_rd(1, 32'h005, "stat0_tc_clr");

`ifdef SPW_BRIDGE_IRQ_EN
        host_wr(6, 32'h1);
        host_rd(6, 32'h1, "ie0_rb");
        check("irq_idle", 32'(irq), 32'd0);
        rx_push(9'h077);
        check("irq_lag", 32'(irq), 32'd0);
        @(negedge clk_clk);
        check("irq_set", 32'(irq), 32'd1);
        rd_rxd("irq_pop");
        @(negedge clk_clk);
        check("irq_clr", 32'(irq), 32'd0);
`else
        host_wr(6, 32'h7);
        host_rd(6, 32'h0, "ie0_off");
`endif

        // reset in the middle of a strobe
        data_tx_ready[1] = 1'b1;
        host_wr(10, 32'h123);
        @(negedge clk_clk);
        check("mid_strobe", 32'(data_en_to_w), 32'd2);
        #1 reset_reset = 1'b1;
        #1;
        check("rst_async_en", 32'(data_en_to_w), 32'd0);
        check("rst_async_txd", 32'(data_tx_to_w), 32'd0);
        data_tx_ready = '0;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        host_rd(9, 32'h0, "stat1_after_rst");

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk_clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
